regfile_wb_ctrl: RTL and testbench
==================================

# regfile_wb_ctrl

Write-back and hazard controller for the 32x32 register file. It arbitrates two write-back sources, the ALU and the load/store unit, onto the register file's single write port through a registered output stage. It also keeps a 32-bit busy scoreboard that stalls issue on RAW and WAW hazards against writes that have not yet landed. It sits between the issue/execute stages and the register file's write port (wen/wAddress/wdata).

## Interface
Parameters:
- XLEN, 32, data width of write-back payloads and register file.
- NREG, 32, number of architectural registers; address width is 5.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock shared with the register file.
- rst  in  1  synchronous active-high reset.
- issue_valid  in  1  issue stage presents an instruction.
- issue_rs1  in  5  source register 1.
- issue_rs2  in  5  source register 2.
- issue_rd  in  5  destination; 0 means no write.
- issue_stall  out  1  combinational hazard stall.
- alu_valid  in  1  ALU write-back request.
- alu_rd  in  5  ALU destination.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU request granted this cycle.
- lsu_valid  in  1  LSU write-back request.
- lsu_rd  in  5  LSU destination.
- lsu_data  in  XLEN  load data.
- lsu_ready  out  1  LSU request granted this cycle.
- rf_wen  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  XLEN  register file write data.
- busy  out  NREG  scoreboard; bit 0 is always 0.

## Operation
**Scoreboard**
- issue_stall = issue_valid & (busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]).
- Register 0 is never busy, so it never causes a stall.
- Issue accepted (issue_valid & !issue_stall & issue_rd != 0) sets busy[issue_rd] at the clock edge.
- busy[rf_waddr] clears at the edge that ends a cycle with rf_wen=1. This is the same edge on which the register file writes.
- Set and clear of the same bit in one cycle cannot occur, because the WAW check stalls the issue. If it is forced, set wins.

**Arbiter**
- Each cycle at most one source is granted: alu_ready and lsu_ready are one-hot or both 0.
- A ready is asserted only when the matching valid is 1.
- Ready depends only on the valids and the arbitration state. There is no back-pressure from the output stage, because it drains every cycle.
- A source holds valid, rd and data stable until it sees ready.
- Default arbitration is fixed priority: the LSU wins a conflict, and the ALU can starve under continuous LSU traffic.

**Output stage**
- On a grant: rf_wen <= (granted rd != 0), rf_waddr <= granted rd, rf_wdata <= granted data.
- With no grant: rf_wen <= 0, and rf_waddr/rf_wdata hold their values.
- A write-back to a register that is not busy is still performed. busy is unchanged.

**Reset**
- rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, alu_ready=0, lsu_ready=0.
- The round-robin pointer is set to LSU-first.
- A reset mid-operation drops any registered write and clears all busy bits. Sources must drop valid under the same reset.

## Timing
- Handshake accepted at edge T (valid & ready in cycle T-1). rf_wen is high during cycle T and the register file writes at edge T+1.
- busy clears at edge T+1. The first non-stalled dependent issue is in cycle T+1, and its read returns the new data.
- Write-back latency is one cycle from grant to rf_wen.
- Throughput is one write per cycle.
- issue_stall and the ready signals are combinational from inputs and state. There is no combinational path from the valid inputs to the rf_* outputs.

## Configuration
- WB_RR_EN defined: two-way round-robin arbitration.
  - On a conflict, grant the source not granted most recently.
  - The pointer updates only on a grant. The reset state favours the LSU.
  - No starvation: each source waits at most 1 cycle under continuous contention.
- WB_RR_EN undefined: fixed priority, LSU over ALU; no pointer register.

## Test plan
- Reset → rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, both readies 0.
- Issue rd=5 → busy[5]=1. Then alu_valid, rd=5, data=0xDEADBEEF → alu_ready same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; following cycle busy[5]=0.
- busy[3]=1 and issue rs2=3 → issue_stall=1. With issue_rs1=0, issue_rs2=0, issue_rd=0 → no stall and no busy change.
- ALU (rd=1, 0x11) and LSU (rd=2, 0x22) valid together for 4 cycles:
  - Fixed priority: LSU granted every cycle, alu_ready=0.
  - WB_RR_EN: grants LSU, ALU, LSU, ALU.
- LSU write-back to rd=0 → lsu_ready=1, next cycle rf_wen=0, busy unchanged.
- rst asserted the cycle after a grant → rf_wen=0 next cycle and busy=0.

Source files
------------

// File: rtl/regfile_wb_ctrl_if.sv
// regfile_wb_ctrl_if: issue, write-back source and register-file write-port signals
interface regfile_wb_ctrl_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32
);
   logic            issue_valid;
   logic [4:0]      issue_rs1;
   logic [4:0]      issue_rs2;
   logic [4:0]      issue_rd;
   logic            issue_stall;
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            alu_ready;
   logic            lsu_valid;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic            lsu_ready;
   logic            rf_wen;
   logic [4:0]      rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic [NREG-1:0] busy;
   modport slave (
      input  issue_valid, issue_rs1, issue_rs2, issue_rd,
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      output issue_stall, alu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata, busy
   );
   modport master (
      output issue_valid, issue_rs1, issue_rs2, issue_rd,
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      input  issue_stall, alu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata, busy
   );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: ALU/LSU write-back arbiter, registered RF write stage and busy scoreboard.
// Define WB_RR_EN for round-robin arbitration; default is fixed priority, LSU over ALU.
module regfile_wb_ctrl #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input logic              clk,
   input logic              rst,
   regfile_wb_ctrl_if.slave wb
);
   logic [NREG-1:0] busy_q, busy_d;
   logic            rf_wen_q, rf_wen_d;
   logic [4:0]      rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
   logic            grant_alu, grant_lsu, issue_ok;
`ifdef WB_RR_EN
   logic lsu_first_q, lsu_first_d;
   always_comb begin
      grant_lsu   = !rst & wb.lsu_valid & (!wb.alu_valid | lsu_first_q);
      grant_alu   = !rst & wb.alu_valid & !grant_lsu;
      lsu_first_d = grant_lsu ? 1'b0 : grant_alu ? 1'b1 : lsu_first_q;
   end
   always_ff @(posedge clk)
      if (rst) lsu_first_q <= 1'b1;
      else     lsu_first_q <= lsu_first_d;
`else
   always_comb begin
      grant_lsu = !rst & wb.lsu_valid;
      grant_alu = !rst & wb.alu_valid & !wb.lsu_valid;
   end
`endif
   always_comb begin
      wb.issue_stall = wb.issue_valid &
                       (busy_q[wb.issue_rs1] | busy_q[wb.issue_rs2] | busy_q[wb.issue_rd]);
      issue_ok       = wb.issue_valid & !wb.issue_stall & (wb.issue_rd != 5'd0);
      busy_d         = busy_q;
      if (rf_wen_q) busy_d[rf_waddr_q] = 1'b0;
      // set after clear so a forced same-bit collision leaves the register busy
      if (issue_ok) busy_d[wb.issue_rd] = 1'b1;
      busy_d[0]      = 1'b0;
      rf_wen_d       = grant_lsu ? (wb.lsu_rd != 5'd0) : grant_alu ? (wb.alu_rd != 5'd0) : 1'b0;
      rf_waddr_d     = grant_lsu ? wb.lsu_rd : grant_alu ? wb.alu_rd : rf_waddr_q;
      rf_wdata_d     = grant_lsu ? wb.lsu_data : grant_alu ? wb.alu_data : rf_wdata_q;
   end
   always_ff @(posedge clk)
      if (rst) begin
         busy_q     <= '0;
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         busy_q     <= busy_d;
         rf_wen_q   <= rf_wen_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   assign wb.alu_ready = grant_alu;
   assign wb.lsu_ready = grant_lsu;
   assign wb.rf_wen    = rf_wen_q;
   assign wb.rf_waddr  = rf_waddr_q;
   assign wb.rf_wdata  = rf_wdata_q;
   assign wb.busy      = busy_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: table-driven vectors plus contention and mid-operation reset sequences
module tb_regfile_wb_ctrl;
   typedef struct {
      logic        iv;
      logic [4:0]  rs1, rs2, rd;
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ld;
      logic        stall, ar, lr, wen;
      logic [4:0]  waddr;
      logic [31:0] wdata, busy;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   regfile_wb_ctrl_if #(.XLEN(32), .NREG(32)) bus ();
   regfile_wb_ctrl #(.XLEN(32), .NREG(32)) dut (.clk(clk), .rst(rst), .wb(bus));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic av, input logic [4:0] ard,
                      input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                      input logic [31:0] ld, input logic stall, input logic ar,
                      input logic lr, input logic wen, input logic [4:0] waddr,
                      input logic [31:0] wdata, input logic [31:0] busy);
      vec_t v;
      v = '{iv, rs1, rs2, rd, av, ard, ad, lv, lrd, ld, stall, ar, lr, wen, waddr, wdata, busy};
      vecs.push_back(v);
   endtask

   task automatic drive(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic av, input logic [4:0] ard,
                        input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                        input logic [31:0] ld);
      bus.issue_valid = iv;
      bus.issue_rs1   = rs1;
      bus.issue_rs2   = rs2;
      bus.issue_rd    = rd;
      bus.alu_valid   = av;
      bus.alu_rd      = ard;
      bus.alu_data    = ad;
      bus.lsu_valid   = lv;
      bus.lsu_rd      = lrd;
      bus.lsu_data    = ld;
   endtask

   task automatic chk_regs(input string tag, input logic wen, input logic [4:0] waddr,
                           input logic [31:0] wdata, input logic [31:0] busy);
      chk({tag, " rf_wen"}, {31'd0, bus.rf_wen}, {31'd0, wen});
      chk({tag, " rf_waddr"}, {27'd0, bus.rf_waddr}, {27'd0, waddr});
      chk({tag, " rf_wdata"}, bus.rf_wdata, wdata);
      chk({tag, " busy"}, bus.busy, busy);
   endtask

   initial begin
      // inputs, then stall/alu_ready/lsu_ready this cycle, then rf_*/busy after the edge
      add(1, 0, 0, 5,  0, 0, 0,            0, 0, 0,        0, 0, 0,  0, 0, 0,            32'h20);
      add(1, 1, 2, 3,  1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 1, 0,  1, 5, 32'hDEADBEEF, 32'h28);
      add(1, 0, 3, 0,  0, 0, 0,            0, 0, 0,        1, 0, 0,  0, 5, 32'hDEADBEEF, 32'h08);
      add(1, 5, 0, 7,  0, 0, 0,            0, 0, 0,        0, 0, 0,  0, 5, 32'hDEADBEEF, 32'h88);
      add(1, 0, 0, 0,  0, 0, 0,            1, 3, 32'h33,   0, 0, 1,  1, 3, 32'h33,       32'h88);
      add(1, 0, 0, 3,  0, 0, 0,            1, 0, 32'h99,   1, 0, 1,  0, 0, 32'h99,       32'h80);
      add(0, 0, 0, 7,  0, 0, 0,            1, 4, 32'h44,   0, 0, 1,  1, 4, 32'h44,       32'h80);
      add(0, 0, 0, 0,  1, 7, 32'h77,       0, 0, 0,        0, 1, 0,  1, 7, 32'h77,       32'h80);
      add(0, 0, 0, 0,  0, 0, 0,            0, 0, 0,        0, 0, 0,  0, 7, 32'h77,       32'h00);

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_regs("reset", 0, 0, 0, 0);
      chk("reset alu_ready", {31'd0, bus.alu_ready}, 0);
      chk("reset lsu_ready", {31'd0, bus.lsu_ready}, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].iv, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].av, vecs[i].ard,
               vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld);
         #1;
         chk($sformatf("v%0d issue_stall", i), {31'd0, bus.issue_stall}, {31'd0, vecs[i].stall});
         chk($sformatf("v%0d alu_ready", i), {31'd0, bus.alu_ready}, {31'd0, vecs[i].ar});
         chk($sformatf("v%0d lsu_ready", i), {31'd0, bus.lsu_ready}, {31'd0, vecs[i].lr});
         @(posedge clk);
         #1;
         chk_regs($sformatf("v%0d", i), vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].busy);
      end

      // contention from a fresh reset: ALU rd=1/0x11 against LSU rd=2/0x22 for four cycles
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         logic alu_turn;
`ifdef WB_RR_EN
         alu_turn = (c % 2) == 1;
`else
         alu_turn = 1'b0;
`endif
         @(negedge clk);
         drive(0, 0, 0, 0, 1, 1, 32'h11, 1, 2, 32'h22);
         #1;
         chk($sformatf("cont%0d alu_ready", c), {31'd0, bus.alu_ready}, {31'd0, alu_turn});
         chk($sformatf("cont%0d lsu_ready", c), {31'd0, bus.lsu_ready}, {31'd0, !alu_turn});
         @(posedge clk);
         #1;
         chk_regs($sformatf("cont%0d", c), 1, alu_turn ? 5'd1 : 5'd2,
                  alu_turn ? 32'h11 : 32'h22, 0);
      end

      // reset the cycle after a grant drops the pending write and the busy bit
      @(negedge clk);
      drive(1, 0, 0, 9, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1 chk("rst-seq busy set", bus.busy, 32'h200);
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 9, 32'h5, 0, 0, 0);
      #1 chk("rst-seq alu_ready", {31'd0, bus.alu_ready}, 1);
      @(posedge clk);
      #1 chk_regs("rst-seq grant", 1, 9, 32'h5, 32'h200);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1 chk_regs("rst-seq after", 0, 0, 0, 0);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
